// File: rtl/fir_coeff_seq_ctrl.sv
// Coefficient-bank sequencer for the reconfigurable FIR: loads host coefficients into the
// SRAM bank, then runs one accumulate sweep plus one sum cycle per sample strobe.
module fir_coeff_seq_ctrl #(
   parameter int unsigned BANK_DEPTH = 10,
   parameter int unsigned MAX_COEFF  = 40,
   parameter int unsigned COEFF_W    = 16
) (
   input  logic               iClk_12M,
   input  logic               iRsn,
   input  logic               iEnSample_600k,
   input  logic               iLoadStart,
   input  logic [5:0]         iLoadNum,
   input  logic               iCoeffVld,
   input  logic [COEFF_W-1:0] iCoeffDt,
   output logic               oCoeffRdy,
   output logic               oCoeffiUpdateFlag,
   output logic               oCsnRam,
   output logic               oWrnRam,
   output logic [3:0]         oAddrRam,
   output logic [COEFF_W-1:0] oWrDtRam,
   output logic [5:0]         oNumOfCoeff,
   output logic               oAccEn,
   output logic               oSumEn,
   output logic               oLoadDone,
   output logic               oLoadErr,
   output logic               oSmpMiss
);

   localparam logic [3:0] AddrLast = 4'(BANK_DEPTH);
   localparam logic [5:0] NumMax   = 6'(MAX_COEFF);

   typedef enum logic [2:0] {StIdle, StLoad, StWaitSmp, StAcc, StSum} state_e;

   state_e state_q, state_d;
   logic [5:0] num_q, num_d;
   logic [5:0] cnt_q, cnt_d;
   logic [5:0] k_q, k_d;
   logic [3:0] slot_q, slot_d;
   logic       pend_q, pend_d;
   logic [5:0] pnum_q, pnum_d;

   logic               rdy_q, rdy_d, flag_q, flag_d, csn_q, csn_d, wrn_q, wrn_d;
   logic [3:0]         addr_q, addr_d;
   logic [COEFF_W-1:0] wrdt_q, wrdt_d;
   logic [5:0]         ncoef_q, ncoef_d;
   logic               acc_q, acc_d, sum_q, sum_d, done_q, done_d;
   logic               err_q, err_d, miss_q, miss_d;

   logic       start;
   logic [5:0] start_num;

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      slot_d    = slot_q;
      pend_d    = pend_q;
      pnum_d    = pnum_q;
      rdy_d     = 1'b0;
      flag_d    = 1'b0;
      csn_d     = 1'b1;
      wrn_d     = 1'b1;
      addr_d    = 4'd0;
      wrdt_d    = wrdt_q;
      ncoef_d   = cnt_q;
      acc_d     = 1'b0;
      sum_d     = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      miss_d    = 1'b0;
      start     = 1'b0;
      start_num = iLoadNum;

      unique case (state_q)
         StIdle: start = iLoadStart;
         StLoad: begin
            flag_d  = 1'b1;
            ncoef_d = k_q;
            miss_d  = iEnSample_600k;
            if (!rdy_q) begin
               // Final write has been issued; publish the loaded count.
               state_d = StWaitSmp;
               flag_d  = 1'b0;
               cnt_d   = num_q;
               ncoef_d = num_q;
            end else if (iCoeffVld) begin
               csn_d  = 1'b0;
               wrn_d  = 1'b0;
               wrdt_d = iCoeffDt;
               addr_d = slot_q + 4'd1;
               k_d    = k_q + 6'd1;
               slot_d = (slot_q == AddrLast - 4'd1) ? 4'd0 : slot_q + 4'd1;
               done_d = (k_q == num_q - 6'd1);
               rdy_d  = (k_q != num_q - 6'd1);
            end else begin
               rdy_d = 1'b1;
            end
         end
         StWaitSmp: begin
            pend_d    = 1'b0;
            start     = pend_q | iLoadStart;
            start_num = pend_q ? pnum_q : iLoadNum;
            if (start) begin
               miss_d = iEnSample_600k;
            end else if (iEnSample_600k) begin
               state_d = StAcc;
               csn_d   = 1'b0;
               acc_d   = 1'b1;
               addr_d  = 4'd1;
            end
         end
         StAcc: begin
            miss_d = iEnSample_600k;
            if (iLoadStart) begin
               pend_d = 1'b1;
               pnum_d = iLoadNum;
            end
            if (addr_q == AddrLast) begin
               state_d = StSum;
               sum_d   = 1'b1;
            end else begin
               csn_d  = 1'b0;
               acc_d  = 1'b1;
               addr_d = addr_q + 4'd1;
            end
         end
         StSum: begin
            miss_d = iEnSample_600k;
            if (iLoadStart) begin
               pend_d = 1'b1;
               pnum_d = iLoadNum;
            end
            state_d = StWaitSmp;
         end
         default: state_d = StIdle;
      endcase

      if (start) begin
         if ((start_num != 6'd0) && (start_num <= NumMax)) begin
            state_d = StLoad;
            num_d   = start_num;
            k_d     = 6'd0;
            slot_d  = 4'd0;
            rdy_d   = 1'b1;
            flag_d  = 1'b1;
            ncoef_d = 6'd0;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         state_q <= StIdle;
         num_q   <= '0;
         cnt_q   <= '0;
         k_q     <= '0;
         slot_q  <= '0;
         pend_q  <= 1'b0;
         pnum_q  <= '0;
         rdy_q   <= 1'b0;
         flag_q  <= 1'b0;
         csn_q   <= 1'b1;
         wrn_q   <= 1'b1;
         addr_q  <= '0;
         wrdt_q  <= '0;
         ncoef_q <= '0;
         acc_q   <= 1'b0;
         sum_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         slot_q  <= slot_d;
         pend_q  <= pend_d;
         pnum_q  <= pnum_d;
         rdy_q   <= rdy_d;
         flag_q  <= flag_d;
         csn_q   <= csn_d;
         wrn_q   <= wrn_d;
         addr_q  <= addr_d;
         wrdt_q  <= wrdt_d;
         ncoef_q <= ncoef_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         done_q  <= done_d;
         err_q   <= err_d;
         miss_q  <= miss_d;
      end
   end

   assign oCoeffRdy         = rdy_q;
   assign oCoeffiUpdateFlag = flag_q;
   assign oCsnRam           = csn_q;
   assign oWrnRam           = wrn_q;
   assign oAddrRam          = addr_q;
   assign oWrDtRam          = wrdt_q;
   assign oNumOfCoeff       = ncoef_q;
   assign oAccEn            = acc_q;
   assign oSumEn            = sum_q;
   assign oLoadDone         = done_q;
   assign oLoadErr          = err_q;
   assign oSmpMiss          = miss_q;

endmodule

// File: tb/tb_fir_coeff_seq_ctrl.sv
// Directed bench for fir_coeff_seq_ctrl: load, sweep, illegal load, collisions, mid-load reset.
module tb_fir_coeff_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        smp, ld_start, vld;
   logic [5:0]  ld_num;
   logic [15:0] dt;
   logic        rdy, flag, csn, wrn, acc, sum, done, err, miss;
   logic [3:0]  addr;
   logic [15:0] wrdt;
   logic [5:0]  ncoef;
   logic [8:0]  st;

   int n_checks = 0;
   int n_fails  = 0;

   logic [15:0] coef [0:32] = '{
      16'h0003, 16'h0000, 16'h0006, 16'hFFF8, 16'h000C, 16'hFFEE, 16'h001A, 16'hFFDA,
      16'h0034, 16'hFFB6, 16'h0068, 16'hFF6A, 16'h00D0, 16'hFED4, 16'h01A0, 16'h0060,
      16'h01F4,
      16'h0060, 16'h01A0, 16'hFED4, 16'h00D0, 16'hFF6A, 16'h0068, 16'hFFB6, 16'h0034,
      16'hFFDA, 16'h001A, 16'hFFEE, 16'h000C, 16'hFFF8, 16'h0006, 16'h0000, 16'h0003};
   logic [5:0] bad [0:1] = '{6'd0, 6'd41};

   fir_coeff_seq_ctrl dut (
      .iClk_12M          (clk),
      .iRsn              (rst_n),
      .iEnSample_600k    (smp),
      .iLoadStart        (ld_start),
      .iLoadNum          (ld_num),
      .iCoeffVld         (vld),
      .iCoeffDt          (dt),
      .oCoeffRdy         (rdy),
      .oCoeffiUpdateFlag (flag),
      .oCsnRam           (csn),
      .oWrnRam           (wrn),
      .oAddrRam          (addr),
      .oWrDtRam          (wrdt),
      .oNumOfCoeff       (ncoef),
      .oAccEn            (acc),
      .oSumEn            (sum),
      .oLoadDone         (done),
      .oLoadErr          (err),
      .oSmpMiss          (miss)
   );

   always #5 clk = ~clk;

   // Status bundle order: rdy flag csn wrn acc sum done err miss
   assign st = {rdy, flag, csn, wrn, acc, sum, done, err, miss};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; smp = 1'b0; ld_start = 1'b0; vld = 1'b0; ld_num = '0; dt = '0;
      step(); step();
      chk("rst_status", 32'(st), 32'(9'b001100000));
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_ncoef", 32'(ncoef), 32'd0);
      chk("rst_wrdt", 32'(wrdt), 32'd0);
      rst_n = 1'b1;
      step();
      smp = 1'b1; step(); smp = 1'b0;
      chk("idle_smp_nomiss", 32'(st), 32'(9'b001100000));

      // Load 33 coefficients back-to-back
      ld_start = 1'b1; ld_num = 6'd33; step(); ld_start = 1'b0;
      chk("load_entry", 32'(st), 32'(9'b111100000));
      chk("load_entry_ncoef", 32'(ncoef), 32'd0);
      vld = 1'b1; dt = coef[0];
      for (int i = 0; i < 33; i++) begin
         step();
         chk("load_wr_status", 32'(st), 32'((i == 32) ? 9'b010000100 : 9'b110000000));
         chk("load_wr_addr", 32'(addr), 32'((i % 10) + 1));
         chk("load_wr_ncoef", 32'(ncoef), 32'(i));
         chk("load_wr_data", 32'(wrdt), 32'(coef[i]));
         if (i < 32) dt = coef[i+1];
         else vld = 1'b0;
      end
      step();
      chk("load_wait_status", 32'(st), 32'(9'b001100000));
      chk("load_wait_ncoef", 32'(ncoef), 32'd33);

      // Five sample sweeps, 20 cycles apart
      for (int s = 0; s < 5; s++) begin
         smp = 1'b1; step(); smp = 1'b0;
         for (int j = 1; j <= 10; j++) begin
            chk("sweep_acc", 32'(st), 32'(9'b000110000));
            chk("sweep_addr", 32'(addr), 32'(j));
            step();
         end
         chk("sweep_sum", 32'(st), 32'(9'b001101000));
         chk("sweep_sum_addr", 32'(addr), 32'd0);
         step();
         chk("sweep_wait", 32'(st), 32'(9'b001100000));
         chk("sweep_wait_ncoef", 32'(ncoef), 32'd33);
         repeat (8) step();
      end

      // Illegal load counts
      for (int b = 0; b < 2; b++) begin
         ld_start = 1'b1; ld_num = bad[b]; step(); ld_start = 1'b0;
         chk("bad_load_err", 32'(st), 32'(9'b001100010));
         step();
         chk("bad_load_after", 32'(st), 32'(9'b001100000));
         chk("bad_load_ncoef", 32'(ncoef), 32'd33);
      end

      // Reload 3 coefficients with a sample strobe during LOAD
      ld_start = 1'b1; ld_num = 6'd3; step(); ld_start = 1'b0;
      chk("ld3_entry", 32'(st), 32'(9'b111100000));
      smp = 1'b1; step(); smp = 1'b0;
      chk("ld3_smp_miss", 32'(st), 32'(9'b111100001));
      vld = 1'b1; dt = 16'hAAAA; step();
      chk("ld3_wr0", 32'(st), 32'(9'b110000000));
      chk("ld3_wr0_addr", 32'(addr), 32'd1);
      chk("ld3_wr0_data", 32'(wrdt), 32'h0000AAAA);
      dt = 16'hBBBB; step();
      chk("ld3_wr1_addr", 32'(addr), 32'd2);
      chk("ld3_wr1_ncoef", 32'(ncoef), 32'd1);
      dt = 16'hCCCC; step();
      chk("ld3_wr2_done", 32'(st), 32'(9'b010000100));
      chk("ld3_wr2_addr", 32'(addr), 32'd3);
      chk("ld3_wr2_data", 32'(wrdt), 32'h0000CCCC);
      vld = 1'b0; step();
      chk("ld3_wait", 32'(st), 32'(9'b001100000));
      chk("ld3_wait_ncoef", 32'(ncoef), 32'd3);

      // Second strobe 5 cycles into ACC
      smp = 1'b1; step(); smp = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         chk("coll_acc", 32'(st), 32'((j == 6) ? 9'b000110001 : 9'b000110000));
         chk("coll_addr", 32'(addr), 32'(j));
         smp = (j == 5);
         step();
      end
      chk("coll_sum", 32'(st), 32'(9'b001101000));
      step();
      chk("coll_wait", 32'(st), 32'(9'b001100000));

      // Load request at ACC cycle 4 becomes pending
      smp = 1'b1; step(); smp = 1'b0;
      ld_num = 6'd10;
      for (int j = 1; j <= 10; j++) begin
         chk("pend_acc", 32'(st), 32'(9'b000110000));
         chk("pend_addr", 32'(addr), 32'(j));
         ld_start = (j == 4);
         step();
      end
      chk("pend_sum", 32'(st), 32'(9'b001101000));
      step();
      chk("pend_wait", 32'(st), 32'(9'b001100000));
      chk("pend_wait_ncoef", 32'(ncoef), 32'd3);
      step();
      chk("pend_load", 32'(st), 32'(9'b111100000));
      chk("pend_load_ncoef", 32'(ncoef), 32'd0);

      // Gapped handshake, then reset after 7 writes
      for (int i = 0; i < 7; i++) begin
         vld = 1'b1; dt = 16'(16'h1000 + i); step();
         chk("gap_wr", 32'(st), 32'(9'b110000000));
         chk("gap_wr_addr", 32'(addr), 32'(i + 1));
         chk("gap_wr_ncoef", 32'(ncoef), 32'(i));
         chk("gap_wr_data", 32'(wrdt), 32'(16'h1000 + i));
         vld = 1'b0; step();
         chk("gap_idle", 32'(st), 32'(9'b111100000));
         chk("gap_idle_ncoef", 32'(ncoef), 32'(i + 1));
      end
      rst_n = 1'b0; #2;
      chk("midrst_status", 32'(st), 32'(9'b001100000));
      chk("midrst_ncoef", 32'(ncoef), 32'd0);
      chk("midrst_addr", 32'(addr), 32'd0);
      rst_n = 1'b1;
      step();
      smp = 1'b1; step(); smp = 1'b0;
      chk("postrst_smp", 32'(st), 32'(9'b001100000));
      step();
      chk("postrst_idle", 32'(st), 32'(9'b001100000));
      chk("postrst_ncoef", 32'(ncoef), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
